// File: rtl/tetris_pkg.sv
// Shared board geometry, cell/colour types and the piece palette.
package tetris_pkg;

  localparam int unsigned BOARD_COLS = 10;
  localparam int unsigned BOARD_ROWS = 20;
  localparam int unsigned TILE_LOG2  = 4;

  typedef logic [2:0]  cell_code_t;
  typedef logic [11:0] rgb_t;

  typedef struct packed {
    logic de;
    logic in_board;
    logic in_frame;
    logic hs;
    logic vs;
  } pix_flags_t;

  // Code 0 (empty) never reaches the tint path; it returns black here.
  function automatic rgb_t palette(input cell_code_t code);
    unique case (code)
      3'd1:    return 12'h0FF;  // I
      3'd2:    return 12'hFF0;  // O
      3'd3:    return 12'hA0F;  // T
      3'd4:    return 12'h0F0;  // S
      3'd5:    return 12'hF00;  // Z
      3'd6:    return 12'h00F;  // J
      3'd7:    return 12'hF80;  // L
      default: return 12'h000;
    endcase
  endfunction

endpackage

// File: rtl/tile_tint.sv
// Combinational per-channel 4x4 multiply with round-up: out = (s*p + 15) >> 4.
module tile_tint
  import tetris_pkg::*;
(
  input  rgb_t i_sprite,
  input  rgb_t i_color,
  output rgb_t o_tinted
);

  // Max 15*15 + 15 = 240, so 8 bits never overflow.
  function automatic logic [3:0] tint_ch(input logic [3:0] s, input logic [3:0] p);
    logic [7:0] m;
    m = 8'(s) * 8'(p) + 8'd15;
    return m[7:4];
  endfunction

  assign o_tinted = {tint_ch(i_sprite[11:8], i_color[11:8]),
                     tint_ch(i_sprite[7:4],  i_color[7:4]),
                     tint_ch(i_sprite[3:0],  i_color[3:0])};

endmodule

// File: rtl/board_tile_renderer.sv
// Playfield pixel stage: raster -> cell/sub-tile address, sprite tint, border frame.
// Fixed 3-clock latency from pix_x/pix_y/de_in to rgb_out/de_out.
module board_tile_renderer
  import tetris_pkg::*;
#(
  parameter int unsigned BOARD_X0     = 240,
  parameter int unsigned BOARD_Y0     = 80,
  parameter int unsigned BORDER_W     = 2,
  parameter logic [11:0] BG_COLOR     = 12'h000,
  parameter logic [11:0] BORDER_COLOR = 12'h555,
  parameter bit          SYNC_ACT_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic        de_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic [3:0]  cell_col,
  output logic [4:0]  cell_row,
  input  logic [2:0]  cell_code,
  output logic [3:0]  sprite_x,
  output logic [3:0]  sprite_y,
  input  logic [11:0] sprite_pixel,
  output logic [11:0] rgb_out,
  output logic        de_out,
  output logic        hsync_out,
  output logic        vsync_out
);

  localparam int unsigned BoardW   = BOARD_COLS << TILE_LOG2;
  localparam int unsigned BoardH   = BOARD_ROWS << TILE_LOG2;
  localparam logic        SyncIdle = SYNC_ACT_LOW;
  localparam pix_flags_t  FlagsRst = '{de: 1'b0, in_board: 1'b0, in_frame: 1'b0,
                                       hs: SyncIdle, vs: SyncIdle};

  logic [31:0] w_px, w_py;
  logic        w_in_board, w_in_outer;
  logic        w_in_frame;
  logic [7:0]  w_rel_x;
  logic [8:0]  w_rel_y;
  rgb_t        w_tinted;
  rgb_t        w_rgb_sel;
  pix_flags_t  r_s1, r_s2;

  assign w_px = 32'(pix_x);
  assign w_py = 32'(pix_y);

  // Compare before subtracting; lower frame bound adds on the pixel side to avoid underflow.
  assign w_in_board = (w_px >= BOARD_X0) && (w_px < BOARD_X0 + BoardW) &&
                      (w_py >= BOARD_Y0) && (w_py < BOARD_Y0 + BoardH);
  assign w_in_outer = (w_px + BORDER_W >= BOARD_X0) && (w_px < BOARD_X0 + BoardW + BORDER_W) &&
                      (w_py + BORDER_W >= BOARD_Y0) && (w_py < BOARD_Y0 + BoardH + BORDER_W);
  assign w_in_frame = w_in_outer && !w_in_board;

  assign w_rel_x = 8'(pix_x - 10'(BOARD_X0));
  assign w_rel_y = 9'(pix_y - 10'(BOARD_Y0));

  tile_tint u_tint (
    .i_sprite (sprite_pixel),
    .i_color  (palette(cell_code)),
    .o_tinted (w_tinted)
  );

  always_comb begin
    w_rgb_sel = BG_COLOR;
    if (!r_s2.de) begin
      w_rgb_sel = 12'h000;
    end else if (r_s2.in_frame) begin
      w_rgb_sel = BORDER_COLOR;
    end else if (r_s2.in_board && cell_code != 3'd0) begin
      w_rgb_sel = w_tinted;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cell_col  <= '0;
      cell_row  <= '0;
      sprite_x  <= '0;
      sprite_y  <= '0;
      r_s1      <= FlagsRst;
      r_s2      <= FlagsRst;
      rgb_out   <= 12'h000;
      de_out    <= 1'b0;
      hsync_out <= SyncIdle;
      vsync_out <= SyncIdle;
    end else begin
      // Off-board pixels leave the RAM/ROM addresses parked; their data is ignored.
      if (w_in_board) begin
        cell_col <= w_rel_x[7:4];
        cell_row <= w_rel_y[8:4];
        sprite_x <= w_rel_x[3:0];
        sprite_y <= w_rel_y[3:0];
      end
      r_s1      <= '{de: de_in, in_board: w_in_board, in_frame: w_in_frame,
                     hs: hsync_in, vs: vsync_in};
      r_s2      <= r_s1;
      rgb_out   <= w_rgb_sel;
      de_out    <= r_s2.de;
      hsync_out <= r_s2.hs;
      vsync_out <= r_s2.vs;
    end
  end

endmodule

// File: tb/tb_board_tile_renderer.sv
// Directed bench for board_tile_renderer: reset, latency, mapping, tint, edges, blanking.
module tb_board_tile_renderer;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  pix_x, pix_y;
  logic        de_in, hsync_in, vsync_in;
  logic [3:0]  cell_col;
  logic [4:0]  cell_row;
  logic [2:0]  cell_code;
  logic [3:0]  sprite_x, sprite_y;
  logic [11:0] sprite_pixel;
  logic [11:0] rgb_out;
  logic        de_out, hsync_out, vsync_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  board_tile_renderer dut (
    .clk          (clk),
    .rst          (rst),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .de_in        (de_in),
    .hsync_in     (hsync_in),
    .vsync_in     (vsync_in),
    .cell_col     (cell_col),
    .cell_row     (cell_row),
    .cell_code    (cell_code),
    .sprite_x     (sprite_x),
    .sprite_y     (sprite_y),
    .sprite_pixel (sprite_pixel),
    .rgb_out      (rgb_out),
    .de_out       (de_out),
    .hsync_out    (hsync_out),
    .vsync_out    (vsync_out)
  );

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int x, input int y, input logic de, input logic [2:0] code,
                       input logic [11:0] spr);
    pix_x        = 10'(x);
    pix_y        = 10'(y);
    de_in        = de;
    cell_code    = code;
    sprite_pixel = spr;
  endtask

  // Hold one pixel for the full pipeline depth and check the colour that emerges.
  task automatic pix_check(input string tag, input int x, input int y, input logic [2:0] code,
                           input logic [11:0] spr, input logic [11:0] exp);
    drive(x, y, 1'b1, code, spr);
    tick(3);
    check(tag, rgb_out, exp);
  endtask

  initial begin
    // 1: reset with active video in the board
    rst = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0;
    drive(277, 165, 1'b1, 3'd5, 12'hFFF);
    tick(4);
    check("rst_rgb", rgb_out, 12'h000);
    check("rst_de", 12'(de_out), 12'h0);
    check("rst_hs", 12'(hsync_out), 12'h1);
    check("rst_vs", 12'(vsync_out), 12'h1);
    check("rst_col", 12'(cell_col), 12'h0);
    rst = 1'b0;
    tick(1);
    check("post_rst1_rgb", rgb_out, 12'h000);
    tick(1);
    check("post_rst2_rgb", rgb_out, 12'h000);
    check("post_rst2_de", 12'(de_out), 12'h0);
    tick(1);
    check("post_rst3_rgb", rgb_out, 12'hF00);
    check("post_rst3_de", 12'(de_out), 12'h1);
    check("post_rst3_hs", 12'(hsync_out), 12'h0);

    // 2: single-cycle de/hsync pulse shows up exactly 3 clocks later
    hsync_in = 1'b1; vsync_in = 1'b1; de_in = 1'b0;
    tick(4);
    de_in = 1'b1; hsync_in = 1'b0;
    tick(1);
    de_in = 1'b0; hsync_in = 1'b1;
    check("lat1_de", 12'(de_out), 12'h0);
    tick(1);
    check("lat2_de", 12'(de_out), 12'h0);
    check("lat2_hs", 12'(hsync_out), 12'h1);
    tick(1);
    check("lat3_de", 12'(de_out), 12'h1);
    check("lat3_hs", 12'(hsync_out), 12'h0);
    tick(1);
    check("lat4_de", 12'(de_out), 12'h0);
    check("lat4_hs", 12'(hsync_out), 12'h1);

    // 3: address mapping one clock after the pixel
    drive(240 + 37, 80 + 85, 1'b1, 3'd0, 12'h000);
    tick(1);
    check("map_col", 12'(cell_col), 12'd2);
    check("map_row", 12'(cell_row), 12'd5);
    check("map_sx", 12'(sprite_x), 12'd5);
    check("map_sy", 12'(sprite_y), 12'd5);

    // 4: tint
    pix_check("tint_z_fff", 277, 165, 3'd5, 12'hFFF, 12'hF00);
    pix_check("tint_z_aaa", 277, 165, 3'd5, 12'hAAA, 12'hA00);
    pix_check("tint_z_888", 277, 165, 3'd5, 12'h888, 12'h800);
    pix_check("tint_empty", 277, 165, 3'd0, 12'hFFF, 12'h000);
    pix_check("tint_i_888", 277, 165, 3'd1, 12'h888, 12'h088);
    pix_check("tint_t_888", 277, 165, 3'd3, 12'h888, 12'h508);
    pix_check("tint_l_fff", 277, 165, 3'd7, 12'hFFF, 12'hF80);
    pix_check("tint_o_000", 277, 165, 3'd2, 12'h000, 12'h000);

    // 5: horizontal and vertical edges
    drive(399, 165, 1'b1, 3'd5, 12'hFFF);
    tick(1);
    check("edge_col9", 12'(cell_col), 12'd9);
    check("edge_sx15", 12'(sprite_x), 12'd15);
    tick(2);
    check("edge_x159", rgb_out, 12'hF00);
    pix_check("edge_x160", 400, 165, 3'd5, 12'hFFF, 12'h555);
    check("edge_hold_col", 12'(cell_col), 12'd9);
    pix_check("edge_x161", 401, 165, 3'd5, 12'hFFF, 12'h555);
    pix_check("edge_x162", 402, 165, 3'd5, 12'hFFF, 12'h000);
    pix_check("edge_xm1", 239, 165, 3'd5, 12'hFFF, 12'h555);
    pix_check("edge_xm2", 238, 165, 3'd5, 12'hFFF, 12'h555);
    pix_check("edge_xm3", 237, 165, 3'd5, 12'hFFF, 12'h000);
    pix_check("edge_x0", 0, 165, 3'd5, 12'hFFF, 12'h000);
    drive(277, 399, 1'b1, 3'd5, 12'hFFF);
    tick(1);
    check("edge_row19", 12'(cell_row), 12'd19);
    check("edge_sy15", 12'(sprite_y), 12'd15);
    tick(2);
    check("edge_y319", rgb_out, 12'hF00);
    pix_check("edge_y320", 277, 400, 3'd5, 12'hFFF, 12'h555);
    pix_check("edge_ym1", 277, 79, 3'd5, 12'hFFF, 12'h555);
    pix_check("edge_y322", 277, 402, 3'd5, 12'hFFF, 12'h000);
    pix_check("edge_corner", 238, 78, 3'd5, 12'hFFF, 12'h555);

    // 6: blanking overrides board content
    drive(277, 165, 1'b0, 3'd3, 12'hFFF);
    tick(3);
    check("blank_rgb", rgb_out, 12'h000);
    check("blank_de", 12'(de_out), 12'h0);

    // Reset mid-frame flushes the pipeline
    drive(277, 165, 1'b1, 3'd5, 12'hFFF);
    tick(3);
    rst = 1'b1;
    tick(1);
    check("midrst_rgb", rgb_out, 12'h000);
    rst = 1'b0;
    tick(2);
    check("midrst_flush", rgb_out, 12'h000);
    tick(1);
    check("midrst_resume", rgb_out, 12'hF00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
